// File: rtl/timer_pkg.sv
// Shared types and default constants for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned CLK_HZ               = 100_000_000;
  localparam int unsigned DEFAULT_TICK_CYCLES  = CLK_HZ;
  localparam int unsigned DEFAULT_BLINK_CYCLES = CLK_HZ / 2;

endpackage

// File: rtl/tick_divider.sv
// Wrapping cycle counter 0 .. CYCLES-1. `strobe` is high in the cycle whose
// rising edge will wrap the counter, so the parent can act on that same edge.
// `clear` wins over `enable`; while neither is high the count holds.
module tick_divider #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic strobe
);

  localparam int unsigned W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign strobe = enable && !clear && (cnt_q == LAST);

  // Next count: clear to zero, advance with wrap, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable once-per-tick down-counter with pause, expiry flag/strobe and a
// free-running blink output. Define COUNTDOWN_TIMER_BLINK_EN to build the
// blink counter; otherwise `blink` is tied low.
//
// Inputs are level-sampled on every rising edge with priority
// start_timer > pause > tick. All outputs come straight from flops.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = DEFAULT_TICK_CYCLES,
  parameter int unsigned BLINK_CYCLES = DEFAULT_BLINK_CYCLES,
  parameter int unsigned VALUE_W      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_timer,
  input  logic               pause,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               expired,
  output logic               expired_pulse,
  output logic               one_hz_enable,
  output logic               blink,
  output logic [VALUE_W-1:0] value_display
);

  state_e             state_q, state_d;
  logic [VALUE_W-1:0] count_q, count_d;
  logic               busy_q, expired_q, pulse_q, pulse_d, hz_q, hz_d;
  logic               tick;
  logic               presc_en;

  // The prescaler only advances while counting and not paused. Leaving
  // PAUSED is counted like a RUN cycle so a pause of P cycles costs P cycles.
  assign presc_en = ((state_q == RUN) || (state_q == PAUSED)) && !pause;

  tick_divider #(.CYCLES(TICK_CYCLES)) u_presc (
    .clock  (clock),
    .reset  (reset),
    .enable (presc_en),
    .clear  (start_timer),
    .strobe (tick)
  );

  // Next-state, count and strobe decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
    hz_d    = 1'b0;
    if (start_timer) begin
      count_d = value;
      if (value == '0) begin
        state_d = DONE;
        pulse_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN, PAUSED: begin
          if (pause) begin
            state_d = PAUSED;
          end else begin
            state_d = RUN;
            if (tick) begin
              hz_d = 1'b1;
              if (count_q <= VALUE_W'(1)) begin
                count_d = '0;
                state_d = DONE;
                pulse_d = 1'b1;
              end else begin
                count_d = count_q - VALUE_W'(1);
              end
            end
          end
        end
        DONE:    count_d = '0;
        default: state_d = state_q;
      endcase
    end
  end

  // State, count and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      hz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= (state_d == RUN) || (state_d == PAUSED);
      expired_q <= (state_d == DONE);
      pulse_q   <= pulse_d;
      hz_q      <= hz_d;
    end
  end

`ifdef COUNTDOWN_TIMER_BLINK_EN
  logic blink_tick;
  logic blink_q;

  tick_divider #(.CYCLES(BLINK_CYCLES)) u_blink (
    .clock  (clock),
    .reset  (reset),
    .enable (1'b1),
    .clear  (1'b0),
    .strobe (blink_tick)
  );

  // Toggle the blink level at every blink-counter wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          blink_q <= 1'b0;
    else if (blink_tick) blink_q <= ~blink_q;
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign busy          = busy_q;
  assign expired       = expired_q;
  assign expired_pulse = pulse_q;
  assign one_hz_enable = hz_q;
  assign value_display = count_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_CYCLES=4, BLINK_CYCLES=3.
module tb_countdown_timer;

  localparam int unsigned TICK  = 4;
  localparam int unsigned BLINK = 3;
  localparam int unsigned VW    = 4;

  // Clock / reset
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start_timer = 1'b0;
  logic          pause = 1'b0;
  logic [VW-1:0] value = '0;
  logic          busy, expired, expired_pulse, one_hz_enable, blink;
  logic [VW-1:0] value_display;

  always #5 clock = ~clock;

  countdown_timer #(
    .TICK_CYCLES  (TICK),
    .BLINK_CYCLES (BLINK),
    .VALUE_W      (VW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
    .pause         (pause),
    .value         (value),
    .busy          (busy),
    .expired       (expired),
    .expired_pulse (expired_pulse),
    .one_hz_enable (one_hz_enable),
    .blink         (blink),
    .value_display (value_display)
  );

  // Scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [VW-1:0] v);
    start_timer = 1'b1;
    value       = v;
    step();
    start_timer = 1'b0;
  endtask

  int hz, pc, cyc, bz;
  logic exp_blink;

  initial begin
    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_disp", value_display, 0);
    check("rst_exp", expired, 0);
    check("rst_pulse", expired_pulse, 0);
    check("rst_hz", one_hz_enable, 0);
    check("rst_blink", blink, 0);
    step();
    reset = 1'b1;
    step();

    // Load 3: decrements at k+4, k+8, k+12
    load(3);
    check("t1_disp0", value_display, 3);
    check("t1_busy0", busy, 1);
    check("t1_exp0", expired, 0);
    hz = 0; pc = 0;
    for (int i = 1; i <= 13; i++) begin
      step();
      hz += int'(one_hz_enable);
      pc += int'(expired_pulse);
      if (i < 4)       check("t1_disp", value_display, 3);
      else if (i < 8)  check("t1_disp", value_display, 2);
      else if (i < 12) check("t1_disp", value_display, 1);
      if (i == 11) check("t1_exp_early", expired, 0);
      if (i == 12) begin
        check("t1_disp_done", value_display, 0);
        check("t1_pulse", expired_pulse, 1);
        check("t1_exp", expired, 1);
        check("t1_busy_done", busy, 0);
        check("t1_hz_last", one_hz_enable, 1);
      end
    end
    check("t1_hz_count", hz, 3);
    check("t1_pulse_count", pc, 1);
    check("t1_exp_hold", expired, 1);

    // Load 0: straight to DONE
    load(0);
    check("t2_exp", expired, 1);
    check("t2_pulse", expired_pulse, 1);
    check("t2_busy", busy, 0);
    check("t2_disp", value_display, 0);
    check("t2_hz", one_hz_enable, 0);
    hz = 0; pc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      hz += int'(one_hz_enable);
      pc += int'(expired_pulse);
    end
    check("t2_hz_count", hz, 0);
    check("t2_pulse_count", pc, 0);
    check("t2_exp_hold", expired, 1);

    // Load 5, pause over the tick due at k+8 for 7 cycles
    load(5);
    check("t3_restart_exp", expired, 0);
    for (int i = 1; i <= 7; i++) step();
    check("t3_disp_pre", value_display, 4);
    pause = 1'b1;
    hz = 0;
    for (int i = 8; i <= 14; i++) begin
      step();
      hz += int'(one_hz_enable);
      check("t3_disp_paused", value_display, 4);
    end
    check("t3_busy_paused", busy, 1);
    check("t3_hz_paused", hz, 0);
    pause = 1'b0;
    step();
    check("t3_disp_resume", value_display, 3);
    check("t3_hz_resume", one_hz_enable, 1);
    cyc = 15;
    while (!expired_pulse && cyc < 60) begin
      step();
      cyc++;
    end
    check("t3_expiry_cycle", cyc, 27);
    pause = 1'b1;
    step();
    check("t3_pause_done_exp", expired, 1);
    check("t3_pause_done_busy", busy, 0);
    pause = 1'b0;

    // Load 9, reload 2 after 6 cycles
    load(9);
    check("t4_restart_exp", expired, 0);
    check("t4_busy", busy, 1);
    for (int i = 1; i <= 5; i++) step();
    load(2);
    check("t4_disp", value_display, 2);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!expired_pulse && cyc < 40);
    check("t4_expiry_cycle", cyc, 8);

    // Reset during RUN with count 4
    load(5);
    for (int i = 1; i <= 4; i++) step();
    check("t5_disp_pre", value_display, 4);
    #2 reset = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_disp", value_display, 0);
    check("t5_exp", expired, 0);
    check("t5_pulse", expired_pulse, 0);
    check("t5_hz", one_hz_enable, 0);
    check("t5_blink", blink, 0);
    step();
    step();
    reset = 1'b1;

    // After release: no strobes, IDLE, blink every 3 cycles when built
    hz = 0; pc = 0; bz = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      hz += int'(one_hz_enable);
      pc += int'(expired_pulse);
      bz += int'(busy);
`ifdef COUNTDOWN_TIMER_BLINK_EN
      exp_blink = ((i / 3) % 2) == 1;
`else
      exp_blink = 1'b0;
`endif
      check("t6_blink", blink, exp_blink);
    end
    check("t5_hz_after", hz, 0);
    check("t5_pulse_after", pc, 0);
    check("t5_busy_after", bz, 0);
    check("t5_disp_after", value_display, 0);
    check("t5_exp_after", expired, 0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
